// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Command codes, DDRAM row bases and scheduler state encoding
//               shared by the LCD frame refresher and its buffer.
// Revision    : 1.0
// ============================================================================
package lcd_pkg;

    localparam logic [2:0] CMD_INIT       = 3'd0;
    localparam logic [2:0] CMD_CLEAR      = 3'd1;
    localparam logic [2:0] CMD_WRITE_CMD  = 3'd2;
    localparam logic [2:0] CMD_WRITE_DATA = 3'd3;
    localparam logic [2:0] CMD_SET_CURSOR = 3'd4;

    localparam logic [6:0] DDRAM_ROW0_BASE = 7'h00;
    localparam logic [6:0] DDRAM_ROW1_BASE = 7'h40;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SCAN      = 3'd1,
        ST_ISSUE_CUR = 3'd2,
        ST_WAIT_CUR  = 3'd3,
        ST_ISSUE_DAT = 3'd4,
        ST_WAIT_DAT  = 3'd5
    } state_t;

    // DDRAM address of a character cell; wraps in 7 bits like the LCD does.
    function automatic logic [6:0] ddram_addr(input logic row, input logic [6:0] col,
                                              input logic [6:0] row1_base);
        return (row ? row1_base : DDRAM_ROW0_BASE) + col;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_frame_buffer
// Description : 2 x COLS character store with per-cell dirty flags.
//               A write to a cell always wins over a same-cycle clear.
// Revision    : 1.0
// ============================================================================
module lcd_frame_buffer #(
    parameter int  COLS  = 16,
    localparam int DEPTH = 2 * COLS,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_addr,
    input  logic [7:0]       wr_data,
    input  logic             refresh_all,
    input  logic             clr_en,
    input  logic [IW-1:0]    clr_idx,
    input  logic [IW-1:0]    rd_idx,
    output logic [7:0]       rd_data,
    output logic [DEPTH-1:0] dirty
);

    logic [7:0]       r_mem [DEPTH];
    logic [DEPTH-1:0] r_dirty;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h20;
            end
        end else if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dirty <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((wr_en && (wr_addr == IW'(i))) || refresh_all) begin
                    r_dirty[i] <= 1'b1;
                end else if (clr_en && (clr_idx == IW'(i))) begin
                    r_dirty[i] <= 1'b0;
                end
            end
        end
    end

    assign rd_data = r_mem[rd_idx];
    assign dirty   = r_dirty;

endmodule
`default_nettype wire

// File: rtl/lcd_frame_refresher.sv
`default_nettype none
// ============================================================================
// Module      : lcd_frame_refresher
// Description : Keeps an HD44780 display in sync with a 2 x COLS frame buffer,
//               sending SET_CURSOR / WRITE_DATA only for changed cells.
// Revision    : 1.0
// ============================================================================
module lcd_frame_refresher
    import lcd_pkg::*;
#(
    parameter int         COLS      = 16,
    parameter logic [6:0] ROW1_BASE = DDRAM_ROW1_BASE,
    localparam int        DEPTH     = 2 * COLS,
    localparam int        IW        = $clog2(DEPTH),
    localparam int        CW        = IW - 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          refresh_all,
    input  logic          lcd_init_done,
    output logic          cmd_valid,
    output logic [2:0]    cmd_type,
    output logic [7:0]    cmd_data,
    input  logic          cmd_ready,
    output logic          busy,
    output logic          frame_clean
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IW-1:0]    r_scan_ptr;
    logic [IW-1:0]    w_scan_ptr_nxt;
    logic [IW-1:0]    r_cursor;
    logic [IW-1:0]    w_cursor_nxt;
    logic             r_cursor_valid;
    logic             w_cursor_valid_nxt;
    logic [7:0]       r_char_q;
    logic [7:0]       w_char_q_nxt;
    logic             w_clr_en;
    logic [7:0]       w_rd_data;
    logic [DEPTH-1:0] w_dirty;
    logic             w_any_dirty;
    logic             w_row;
    logic [CW-1:0]    w_col;
    logic [6:0]       w_cur_addr;

    lcd_frame_buffer #(
        .COLS (COLS)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .refresh_all (refresh_all),
        .clr_en      (w_clr_en),
        .clr_idx     (r_scan_ptr),
        .rd_idx      (r_scan_ptr),
        .rd_data     (w_rd_data),
        .dirty       (w_dirty)
    );

    assign w_any_dirty = |w_dirty;
    assign w_row       = r_scan_ptr[IW-1];
    assign w_col       = r_scan_ptr[CW-1:0];
    assign w_cur_addr  = ddram_addr(w_row, 7'(w_col), ROW1_BASE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_scan_ptr     <= '0;
            r_cursor       <= '0;
            r_cursor_valid <= 1'b0;
            r_char_q       <= 8'h00;
        end else begin
            r_state        <= w_state_nxt;
            r_scan_ptr     <= w_scan_ptr_nxt;
            r_cursor       <= w_cursor_nxt;
            r_cursor_valid <= w_cursor_valid_nxt;
            r_char_q       <= w_char_q_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_scan_ptr_nxt     = r_scan_ptr;
        w_cursor_nxt       = r_cursor;
        w_cursor_valid_nxt = r_cursor_valid;
        w_char_q_nxt       = r_char_q;
        w_clr_en           = 1'b0;
        cmd_valid          = 1'b0;
        cmd_type           = 3'd0;
        cmd_data           = 8'h00;

        case (r_state)
            ST_IDLE: begin
                if (lcd_init_done && cmd_ready && w_any_dirty) begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // Losing init between commands parks the scheduler with dirty cells intact.
                if (!w_any_dirty || !lcd_init_done) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_dirty[r_scan_ptr]) begin
                    w_char_q_nxt = w_rd_data;
                    w_clr_en     = 1'b1;
                    if (r_cursor_valid && (r_cursor == r_scan_ptr)) begin
                        w_state_nxt = ST_ISSUE_DAT;
                    end else begin
                        w_state_nxt = ST_ISSUE_CUR;
                    end
                end else begin
                    w_scan_ptr_nxt = r_scan_ptr + IW'(1);
                end
            end
            ST_ISSUE_CUR: begin
                cmd_valid = 1'b1;
                cmd_type  = CMD_SET_CURSOR;
                cmd_data  = {1'b0, w_cur_addr};
                if (!cmd_ready) begin
                    w_state_nxt = ST_WAIT_CUR;
                end
            end
            ST_WAIT_CUR: begin
                if (cmd_ready) begin
                    w_state_nxt = ST_ISSUE_DAT;
                end
            end
            ST_ISSUE_DAT: begin
                cmd_valid = 1'b1;
                cmd_type  = CMD_WRITE_DATA;
                cmd_data  = r_char_q;
                if (!cmd_ready) begin
                    w_state_nxt = ST_WAIT_DAT;
                end
            end
            ST_WAIT_DAT: begin
                // The LCD auto-increments into hidden DDRAM past the last column.
                if (cmd_ready) begin
                    w_cursor_nxt       = r_scan_ptr + IW'(1);
                    w_cursor_valid_nxt = (w_col != CW'(COLS - 1));
                    w_scan_ptr_nxt     = r_scan_ptr + IW'(1);
                    w_state_nxt        = ST_SCAN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (refresh_all) begin
            w_cursor_valid_nxt = 1'b0;
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign frame_clean = !w_any_dirty && (r_state == ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_lcd_frame_refresher.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_frame_refresher
// Description : Self-checking bench with an LCD controller responder and a
//               cell-level model of the expected command stream.
// Revision    : 1.0
// ============================================================================
module tb_lcd_frame_refresher;

    localparam int COLS  = 16;
    localparam int DEPTH = 2 * COLS;
    localparam int NBUSY = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       refresh_all;
    logic       lcd_init_done;
    logic       cmd_valid;
    logic [2:0] cmd_type;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       busy;
    logic       frame_clean;

    int tests = 0;
    int fails = 0;
    int vcount = 0;
    int busy_cnt = 0;

    logic [10:0] got[$];
    logic [10:0] expq[$];

    logic [7:0] mbuf [DEPTH];
    bit         mdirty [DEPTH];
    int         mp;
    int         mcur;
    bit         mcv;

    always #5 clk = ~clk;

    lcd_frame_refresher #(
        .COLS      (COLS),
        .ROW1_BASE (7'h40)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .refresh_all   (refresh_all),
        .lcd_init_done (lcd_init_done),
        .cmd_valid     (cmd_valid),
        .cmd_type      (cmd_type),
        .cmd_data      (cmd_data),
        .cmd_ready     (cmd_ready),
        .busy          (busy),
        .frame_clean   (frame_clean)
    );

    // LCD controller stand-in: accept, go busy, become ready NBUSY cycles later.
    initial begin
        cmd_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (cmd_valid) vcount++;
            if (cmd_ready && cmd_valid) begin
                got.push_back({cmd_type, cmd_data});
                cmd_ready = 1'b0;
                busy_cnt  = NBUSY;
            end else if (!cmd_ready) begin
                busy_cnt--;
                if (busy_cnt <= 0) cmd_ready = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mbuf[i]   = 8'h20;
            mdirty[i] = 1'b0;
        end
        mp   = 0;
        mcur = 0;
        mcv  = 1'b0;
    endfunction

    function automatic void m_write(input int a, input logic [7:0] d);
        mbuf[a]   = d;
        mdirty[a] = 1'b1;
    endfunction

    function automatic void m_refresh();
        for (int i = 0; i < DEPTH; i++) mdirty[i] = 1'b1;
        mcv = 1'b0;
    endfunction

    // Walk forward from the resume point; each dirty cell costs one data byte,
    // plus a cursor move unless the display cursor already sits on it.
    function automatic void m_drain();
        int start;
        start = mp;
        for (int k = 0; k < DEPTH; k++) begin
            int i;
            int addr;
            logic [6:0] a7;
            i = (start + k) % DEPTH;
            if (mdirty[i]) begin
                if (!(mcv && mcur == i)) begin
                    addr = ((i >= COLS) ? 'h40 : 'h00) + (i % COLS);
                    a7   = 7'(addr);
                    expq.push_back({3'd4, 1'b0, a7});
                end
                expq.push_back({3'd3, mbuf[i]});
                mdirty[i] = 1'b0;
                mcur = (i + 1) % DEPTH;
                mcv  = ((i % COLS) != COLS - 1);
                mp   = (i + 1) % DEPTH;
            end
        end
    endfunction

    task automatic wr(input int a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = 5'(a);
        wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        m_write(a, d);
    endtask

    task automatic pulse_refresh();
        refresh_all = 1'b1;
        @(posedge clk); #1;
        refresh_all = 1'b0;
        m_refresh();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
    endtask

    task automatic drain_and_compare(input string tag);
        int cyc;
        int n;
        cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        while (!(frame_clean && cmd_ready) && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " drain_timeout"}, 32'(cyc < 5000), 32'd1);
        m_drain();
        check({tag, " cmd_count"}, got.size(), expq.size());
        n = (got.size() < expq.size()) ? got.size() : expq.size();
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s cmd%0d", tag, k), 32'(got[k]), 32'(expq[k]));
        end
        check({tag, " frame_clean"}, 32'(frame_clean), 32'd1);
        got.delete();
        expq.delete();
    endtask

    initial begin
        int v0;
        int cyc;
        int n;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        refresh_all = 1'b0; lcd_init_done = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst cmd_valid",   32'(cmd_valid),   32'd0);
        check("rst busy",        32'(busy),        32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset cmd_valid",   32'(cmd_valid),   32'd0);
        check("reset cmd_type",    32'(cmd_type),    32'd0);
        check("reset cmd_data",    32'(cmd_data),    32'd0);
        check("reset busy",        32'(busy),        32'd0);
        check("reset frame_clean", 32'(frame_clean), 32'd1);

        // Contiguous run: one cursor move, three data bytes.
        lcd_init_done = 1'b1;
        wr(0, 8'h41); wr(1, 8'h42); wr(2, 8'h43);
        drain_and_compare("t1_abc");

        wr(17, 8'h5A);
        drain_and_compare("t2_z");
        wr(18, 8'h59);
        drain_and_compare("t2_next");

        wr(15, 8'h31); wr(16, 8'h32);
        drain_and_compare("t3_rowcross");

        // Re-dirty a cell while its data byte is in flight.
        wr(5, 8'h50);
        cyc = 0;
        while (got.size() < 2 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("t4 first_data_timeout", 32'(cyc < 2000), 32'd1);
        m_drain();
        wr(5, 8'h51);
        drain_and_compare("t4_redirty");

        do_reset();
        pulse_refresh();
        drain_and_compare("t5_refresh");

        // Randomized rounds written while init is low, then released.
        for (int r = 0; r < 4; r++) begin
            lcd_init_done = 1'b0;
            v0 = vcount;
            n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++) begin
                wr($urandom_range(0, DEPTH - 1), 8'($urandom_range(33, 126)));
            end
            if (r == 2) pulse_refresh();
            if (r == 3) begin
                refresh_all = 1'b1;
                wr($urandom_range(0, DEPTH - 1), 8'($urandom_range(33, 126)));
                refresh_all = 1'b0;
                m_refresh();
            end
            repeat (30) @(posedge clk);
            #1;
            check($sformatf("t6 r%0d no_cmd", r), vcount - v0, 0);
            check($sformatf("t6 r%0d idle", r), 32'(busy), 32'd0);
            check($sformatf("t6 r%0d not_clean", r), 32'(frame_clean), 32'd0);
            lcd_init_done = 1'b1;
            drain_and_compare($sformatf("t6_rand%0d", r));
        end

        // Reset while a data byte is being offered.
        wr(3, 8'h52);
        cyc = 0;
        @(negedge clk);
        while (!(cmd_valid && cmd_type == 3'd3) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("t6 issue_dat_timeout", 32'(cyc < 2000), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6 rst cmd_valid",   32'(cmd_valid),   32'd0);
        check("t6 rst cmd_type",    32'(cmd_type),    32'd0);
        check("t6 rst cmd_data",    32'(cmd_data),    32'd0);
        check("t6 rst busy",        32'(busy),        32'd0);
        check("t6 rst frame_clean", 32'(frame_clean), 32'd1);
        rst = 1'b0;
        cyc = 0;
        while (!cmd_ready && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("t6 ready_return", 32'(cmd_ready), 32'd1);
        got.delete();
        m_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
